// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared constants and types for the multi-port register file
package regfile_mp_pkg;

  localparam int RF_DATA_W    = 32;
  localparam int RF_ADDR_W    = 5;
  localparam int RF_NRD       = 2;
  localparam int RF_ZERO_ADDR = 0;

  // Where a read port takes its data from in the current cycle.
  typedef enum logic [1:0] {
    SRC_ARRAY = 2'd0,
    SRC_WR0   = 2'd1,
    SRC_WR1   = 2'd2,
    SRC_ZERO  = 2'd3
  } rd_src_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-bit array and busy counter for issued destinations
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NRD      = RF_NRD,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr0_en_i,
  input  logic [ADDR_W-1:0]     wr0_addr_i,
  input  logic                  wr1_en_i,
  input  logic [ADDR_W-1:0]     wr1_addr_i,
  input  logic                  iss_en_i,
  input  logic [ADDR_W-1:0]     iss_addr_i,
  input  logic                  flush_i,
  input  logic [NRD*ADDR_W-1:0] rd_addr_i,
  output logic [NRD-1:0]        rd_busy_o,
  output logic [ADDR_W:0]       busy_cnt_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(RF_ZERO_ADDR);

  logic [DEPTH-1:0] r_pending;
  logic [ADDR_W:0]  r_cnt;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;
  logic [DEPTH-1:0] w_pend_nxt;
  logic [ADDR_W:0]  w_cnt_nxt;
  logic             w_iss_ok;

  assign w_iss_ok = iss_en_i && !(ZERO_REG != 0 && iss_addr_i == ZADDR);

  // Write enables arrive already filtered for the zero register; an issue to
  // the same address masks the clear so the new producer keeps it pending.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_iss_ok) w_set[iss_addr_i] = 1'b1;
    if (wr0_en_i) w_clr[wr0_addr_i] = 1'b1;
    if (wr1_en_i) w_clr[wr1_addr_i] = 1'b1;
    w_clr = w_clr & ~w_set;
  end

  always_comb begin
    w_pend_nxt = flush_i ? '0 : ((r_pending | w_set) & ~w_clr);
    w_cnt_nxt  = '0;
    for (int a = 0; a < DEPTH; a++) begin
      w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_pend_nxt[a]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_busy
    logic [ADDR_W-1:0] w_addr;
    assign w_addr       = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign rd_busy_o[k] = rst_i && r_pending[w_addr] && !w_clr[w_addr];
  end

  assign busy_cnt_o = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read, dual-write register file with write-through bypass and scoreboard
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NRD      = RF_NRD,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NRD*ADDR_W-1:0] rd_addr_i,
  output logic [NRD*DATA_W-1:0] rd_data_o,
  output logic [NRD-1:0]        rd_busy_o,
  input  logic                  wr0_en_i,
  input  logic [ADDR_W-1:0]     wr0_addr_i,
  input  logic [DATA_W-1:0]     wr0_data_i,
  input  logic                  wr1_en_i,
  input  logic [ADDR_W-1:0]     wr1_addr_i,
  input  logic [DATA_W-1:0]     wr1_data_i,
  input  logic                  iss_en_i,
  input  logic [ADDR_W-1:0]     iss_addr_i,
  input  logic                  flush_i,
  output logic [ADDR_W:0]       busy_cnt_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(RF_ZERO_ADDR);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr0_en;
  logic              w_wr1_en;

  // Writes to the hardwired zero register are dropped before storage,
  // bypass and scoreboard see them.
  assign w_wr0_en = wr0_en_i && !(ZERO_REG != 0 && wr0_addr_i == ZADDR);
  assign w_wr1_en = wr1_en_i && !(ZERO_REG != 0 && wr1_addr_i == ZADDR);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr0_en) r_mem[wr0_addr_i] <= wr0_data_i;
      if (w_wr1_en) r_mem[wr1_addr_i] <= wr1_data_i;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    rd_src_e           w_src;

    assign w_addr = rd_addr_i[k*ADDR_W +: ADDR_W];

    // Port 1 is checked first so it wins bypass on a same-address collision.
    always_comb begin
      if (!rst_i || (ZERO_REG != 0 && w_addr == ZADDR)) w_src = SRC_ZERO;
      else if (w_wr1_en && wr1_addr_i == w_addr)        w_src = SRC_WR1;
      else if (w_wr0_en && wr0_addr_i == w_addr)        w_src = SRC_WR0;
      else                                              w_src = SRC_ARRAY;
    end

    always_comb begin
      case (w_src)
        SRC_WR1:   w_data = wr1_data_i;
        SRC_WR0:   w_data = wr0_data_i;
        SRC_ARRAY: w_data = r_mem[w_addr];
        default:   w_data = '0;
      endcase
    end

    assign rd_data_o[k*DATA_W +: DATA_W] = w_data;
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr0_en_i   (w_wr0_en),
    .wr0_addr_i (wr0_addr_i),
    .wr1_en_i   (w_wr1_en),
    .wr1_addr_i (wr1_addr_i),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .flush_i    (flush_i),
    .rd_addr_i  (rd_addr_i),
    .rd_busy_o  (rd_busy_o),
    .busy_cnt_o (busy_cnt_o)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 32;

  logic              clk;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr0_en;
  logic [AW-1:0]     wr0_addr;
  logic [DW-1:0]     wr0_data;
  logic              wr1_en;
  logic [AW-1:0]     wr1_addr;
  logic [DW-1:0]     wr1_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              flush;
  logic [AW:0]       busy_cnt;

  int checks;
  int errors;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] m_mem [DEPTH];
  logic [DEPTH-1:0] m_pend;

  regfile_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NRD      (NRD),
    .ZERO_REG (1)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .wr0_en_i   (wr0_en),
    .wr0_addr_i (wr0_addr),
    .wr0_data_i (wr0_data),
    .wr1_en_i   (wr1_en),
    .wr1_addr_i (wr1_addr),
    .wr1_data_i (wr1_data),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .flush_i    (flush),
    .busy_cnt_o (busy_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 100000", $time);
    $fatal(1);
  end

  task automatic idle();
    wr0_en = 0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    iss_en = 0; iss_addr = '0; flush = 0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  function automatic void push_exp(input string tag, input int port, input logic [31:0] val);
    exp_t x;
    x.tag = tag; x.port = port; x.val = val;
    exp_q.push_back(x);
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    if (!rst || a == 0) return 32'h0;
    if (wr1_en && int'(wr1_addr) == a) return wr1_data;
    if (wr0_en && int'(wr0_addr) == a) return wr0_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int a);
    logic wr_hit;
    wr_hit = ((wr0_en && int'(wr0_addr) == a) || (wr1_en && int'(wr1_addr) == a)) && a != 0;
    if (!rst) return 1'b0;
    return m_pend[a] && !(wr_hit && !(iss_en && int'(iss_addr) == a));
  endfunction

  // Called right after a rising edge while inputs are still those sampled.
  task automatic model_edge();
    logic [DEPTH-1:0] nxt;
    if (!rst) return;
    if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
    if (wr1_en && wr1_addr != 0) m_mem[wr1_addr] = wr1_data;
    for (int a = 0; a < DEPTH; a++) begin
      if (flush) nxt[a] = 1'b0;
      else if (iss_en && int'(iss_addr) == a && a != 0) nxt[a] = 1'b1;
      else if (((wr0_en && int'(wr0_addr) == a) || (wr1_en && int'(wr1_addr) == a)) && a != 0) nxt[a] = 1'b0;
      else nxt[a] = m_pend[a];
    end
    m_pend = nxt;
  endtask

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    m_pend = '0;
  endtask

  task automatic test_reset();
    idle();
    wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'hAAAA5555;
    iss_en = 1; iss_addr = 5'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a, DEPTH - 1 - a);
      #1;
      push_exp("reset_rd_p0", 0, 32'h0);
      push_exp("reset_rd_p1", 1, 32'h0);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); checks++;
        if (rd_data[e.port*DW +: DW] !== e.val) begin
          errors++; $display("FAIL %s addr %0d got %h exp %h", e.tag, a, rd_data[e.port*DW +: DW], e.val);
        end
      end
    end
    checks++;
    if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp 00", rd_busy); end
    checks++;
    if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", busy_cnt); end
    @(negedge clk);
    idle();
    rst = 1;
    model_reset();
    @(posedge clk); model_edge(); #1;
    @(negedge clk);
    set_rd(5, 7);
    #1;
    push_exp("reset_discard_wr", 0, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_data[e.port*DW +: DW] !== e.val) begin
        errors++; $display("FAIL %s got %h exp %h", e.tag, rd_data[e.port*DW +: DW], e.val);
      end
    end
    checks++;
    if (rd_busy !== 2'b00 || busy_cnt !== 6'd0) begin
      errors++; $display("FAIL reset_discard_iss busy %b cnt %0d exp 00 0", rd_busy, busy_cnt);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle();
    wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    set_rd(5, 6);
    #1;
    push_exp("bypass_p0", 0, 32'hDEADBEEF);
    push_exp("bypass_p1_other", 1, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_data[e.port*DW +: DW] !== e.val) begin
        errors++; $display("FAIL %s got %h exp %h", e.tag, rd_data[e.port*DW +: DW], e.val);
      end
    end
    @(posedge clk); model_edge();
    @(negedge clk);
    idle();
    set_rd(5, 5);
    #1;
    push_exp("bypass_stored_p0", 0, 32'hDEADBEEF);
    push_exp("bypass_stored_p1", 1, 32'hDEADBEEF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_data[e.port*DW +: DW] !== e.val) begin
        errors++; $display("FAIL %s got %h exp %h", e.tag, rd_data[e.port*DW +: DW], e.val);
      end
    end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    idle();
    wr0_en = 1; wr0_addr = 5'd9; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 5'd9; wr1_data = 32'h22;
    set_rd(9, 9);
    #1;
    push_exp("dual_bypass_p0", 0, 32'h22);
    push_exp("dual_bypass_p1", 1, 32'h22);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_data[e.port*DW +: DW] !== e.val) begin
        errors++; $display("FAIL %s got %h exp %h", e.tag, rd_data[e.port*DW +: DW], e.val);
      end
    end
    @(posedge clk); model_edge();
    @(negedge clk);
    idle();
    #1;
    push_exp("dual_stored_p0", 0, 32'h22);
    push_exp("dual_stored_p1", 1, 32'h22);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_data[e.port*DW +: DW] !== e.val) begin
        errors++; $display("FAIL %s got %h exp %h", e.tag, rd_data[e.port*DW +: DW], e.val);
      end
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    idle();
    wr0_en = 1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
    wr1_en = 1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
    iss_en = 1; iss_addr = 5'd0;
    set_rd(0, 0);
    #1;
    push_exp("zero_bypass_p0", 0, 32'h0);
    push_exp("zero_bypass_p1", 1, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_data[e.port*DW +: DW] !== e.val) begin
        errors++; $display("FAIL %s got %h exp %h", e.tag, rd_data[e.port*DW +: DW], e.val);
      end
    end
    @(posedge clk); model_edge(); #1;
    checks++;
    if (busy_cnt !== 6'd0 || rd_busy !== 2'b00) begin
      errors++; $display("FAIL zero_iss cnt %0d busy %b exp 0 00", busy_cnt, rd_busy);
    end
    @(negedge clk);
    idle();
    #1;
    push_exp("zero_stored_p0", 0, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_data[e.port*DW +: DW] !== e.val) begin
        errors++; $display("FAIL %s got %h exp %h", e.tag, rd_data[e.port*DW +: DW], e.val);
      end
    end
  endtask

  task automatic test_issue();
    @(negedge clk);
    idle();
    iss_en = 1; iss_addr = 5'd3;
    set_rd(3, 4);
    @(posedge clk); model_edge(); #1;
    checks++;
    if (rd_busy !== 2'b01 || busy_cnt !== 6'd1) begin
      errors++; $display("FAIL issue_set busy %b cnt %0d exp 01 1", rd_busy, busy_cnt);
    end
    @(negedge clk);
    idle();
    iss_en = 1; iss_addr = 5'd3;
    wr1_en = 1; wr1_addr = 5'd3; wr1_data = 32'h33;
    #1;
    checks++;
    if (rd_busy !== 2'b01) begin errors++; $display("FAIL issue_wins_comb busy %b exp 01", rd_busy); end
    push_exp("issue_wr1_bypass", 0, 32'h33);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_data[e.port*DW +: DW] !== e.val) begin
        errors++; $display("FAIL %s got %h exp %h", e.tag, rd_data[e.port*DW +: DW], e.val);
      end
    end
    @(posedge clk); model_edge(); #1;
    checks++;
    if (rd_busy !== 2'b01 || busy_cnt !== 6'd1) begin
      errors++; $display("FAIL issue_wins busy %b cnt %0d exp 01 1", rd_busy, busy_cnt);
    end
    @(negedge clk);
    idle();
    wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'h44;
    #1;
    checks++;
    if (rd_busy !== 2'b00) begin errors++; $display("FAIL clear_bypass busy %b exp 00", rd_busy); end
    @(posedge clk); model_edge(); #1;
    checks++;
    if (rd_busy !== 2'b00 || busy_cnt !== 6'd0) begin
      errors++; $display("FAIL clear_edge busy %b cnt %0d exp 00 0", rd_busy, busy_cnt);
    end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      iss_en = 1; iss_addr = AW'(1 << i);
      @(posedge clk); model_edge();
    end
    #1;
    checks++;
    if (busy_cnt !== 6'd3) begin errors++; $display("FAIL flush_pre_cnt got %0d exp 3", busy_cnt); end
    @(negedge clk);
    idle();
    flush = 1;
    wr0_en = 1; wr0_addr = 5'd2; wr0_data = 32'h7;
    iss_en = 1; iss_addr = 5'd5;
    set_rd(2, 1);
    @(posedge clk); model_edge(); #1;
    checks++;
    if (busy_cnt !== 6'd0 || rd_busy !== 2'b00) begin
      errors++; $display("FAIL flush_clear cnt %0d busy %b exp 0 00", busy_cnt, rd_busy);
    end
    @(negedge clk);
    idle();
    set_rd(2, 5);
    #1;
    push_exp("flush_wr_p0", 0, 32'h7);
    push_exp("flush_keep_p1", 1, 32'hDEADBEEF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_data[e.port*DW +: DW] !== e.val) begin
        errors++; $display("FAIL %s got %h exp %h", e.tag, rd_data[e.port*DW +: DW], e.val);
      end
    end
    iss_en = 1; iss_addr = 5'd5;
    @(posedge clk); model_edge();
    #2;
    wr0_en = 1; wr0_addr = 5'd2; wr0_data = 32'h99;
    rst = 0;
    model_reset();
    #1;
    push_exp("midrst_p0", 0, 32'h0);
    push_exp("midrst_p1", 1, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_data[e.port*DW +: DW] !== e.val) begin
        errors++; $display("FAIL %s got %h exp %h", e.tag, rd_data[e.port*DW +: DW], e.val);
      end
    end
    checks++;
    if (busy_cnt !== 6'd0 || rd_busy !== 2'b00) begin
      errors++; $display("FAIL midrst_sb cnt %0d busy %b exp 0 00", busy_cnt, rd_busy);
    end
    @(negedge clk);
    idle();
    rst = 1;
    @(posedge clk); model_edge();
    @(negedge clk);
    set_rd(2, 5);
    #1;
    push_exp("postrst_p0", 0, 32'h0);
    push_exp("postrst_p1", 1, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_data[e.port*DW +: DW] !== e.val) begin
        errors++; $display("FAIL %s got %h exp %h", e.tag, rd_data[e.port*DW +: DW], e.val);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      wr0_en = 1'($urandom_range(0, 1)); wr0_addr = AW'($urandom_range(0, 7)); wr0_data = $urandom;
      wr1_en = 1'($urandom_range(0, 1)); wr1_addr = AW'($urandom_range(0, 7)); wr1_data = $urandom;
      iss_en = 1'($urandom_range(0, 1)); iss_addr = AW'($urandom_range(0, 7));
      flush = ($urandom_range(0, 15) == 0);
      a0 = $urandom_range(0, 8);
      a1 = (cyc % 3 == 0) ? int'(wr1_addr) : $urandom_range(0, 8);
      set_rd(a0, a1);
      #1;
      push_exp("rand_rd_p0", 0, exp_rd(a0));
      push_exp("rand_rd_p1", 1, exp_rd(a1));
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); checks++;
        if (rd_data[e.port*DW +: DW] !== e.val) begin
          errors++; $display("FAIL %s cyc %0d got %h exp %h", e.tag, cyc, rd_data[e.port*DW +: DW], e.val);
        end
      end
      checks++;
      if (rd_busy !== {exp_busy(a1), exp_busy(a0)}) begin
        errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", cyc, rd_busy, {exp_busy(a1), exp_busy(a0)});
      end
      @(posedge clk); model_edge(); #1;
      checks++;
      if (busy_cnt !== 6'($countones(m_pend))) begin
        errors++; $display("FAIL rand_cnt cyc %0d got %0d exp %0d", cyc, busy_cnt, $countones(m_pend));
      end
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 0;
    rd_addr = '0;
    idle();
    model_reset();
    test_reset();
    test_bypass();
    test_dual_write();
    test_zero_reg();
    test_issue();
    test_flush_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
